mdio_master: RTL
================

# mdio_master

Parametrised MDIO management master for PHY register access, supporting both IEEE 802.3 Clause 22 and Clause 45 frames. It adds a runtime-programmable MDC divider, optional preamble suppression, a valid/ready command interface and a read-response channel with turnaround-error reporting. It sits between the register/CPU bridge and the tri-state MDIO pad; the pad buffer lives outside this block.

## Interface
- DIV_W, 8: width of the runtime divider `cfg_div`.
- PRE_LEN, 32: preamble length in bits, range 1..63.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_div  in  DIV_W  MDC half-period minus one, in clk cycles; MDC period = 2*(cfg_div+1)
- cfg_pre_en  in  1  1 = send preamble; 0 = suppress it
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted (IDLE)
- cmd_c45  in  1  0 = Clause 22 (ST=01); 1 = Clause 45 (ST=00)
- cmd_op  in  2  OP field, driven verbatim
- cmd_phy  in  5  PHYAD / PRTAD
- cmd_reg  in  5  REGAD / DEVAD
- cmd_data  in  16  write data or C45 address; ignored for reads
- rsp_valid  out  1  one-cycle pulse when a frame completes
- rsp_data  out  16  read data; 0 after write-type frames
- rsp_err  out  1  turnaround error on a read
- busy  out  1  high from accept until rsp_valid, inclusive
- mdc  out  1  management clock
- mdio_o  out  1  output data to the pad
- mdio_t  out  1  1 = release the pad (high-Z)
- mdio_i  in  1  input data from the pad

## Operation
- **Accept:** a command is accepted when cmd_valid & cmd_ready. All cmd_* fields, cfg_div and cfg_pre_en are latched at accept; later changes do not affect the frame in flight. cmd_valid is ignored while busy.
- **Read-type decode:**
  - Clause 45: cmd_op[1]=1 (11 = read, 10 = post-read-increment).
  - Clause 22: cmd_op == 10.
  - All other op codes are write-type, including C22 00 and 11.
- **States:** IDLE -> PRE (PRE_LEN bits; skipped if pre disabled) -> HDR (14 bits: ST, OP, PHY, REG, MSB first) -> TA (2 bits) -> DATA (16 bits, MSB first) -> DONE (1 clk) -> IDLE.
- **Write-type frames:** mdio_t=0 for the whole frame; TA driven as 1,0; DATA = cmd_data.
- **Read-type frames:**
  - mdio_t=1 from the start of the first TA bit to the end of DATA.
  - The second TA bit is sampled and expected to be 0; if it is 1, rsp_err=1. Data is still captured in this case.
  - The 16 DATA bits are shifted into rsp_data MSB first.
- **Preamble:** mdio_o=1 and mdio_t=0 throughout.
- **IDLE and DONE:** mdio_t=1, mdio_o=1, mdc=0.
- **Outputs:** all outputs are registered.
- **Reset values:** mdc=0, mdio_t=1, mdio_o=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, state IDLE.
- **Reset mid-frame:** asynchronously aborts the frame. No rsp_valid is issued, and all outputs return to reset values immediately.

## Timing
- **Bit period:** 2*(cfg_div+1) clk cycles.
  - MDC low phase first (cfg_div+1 cycles), then high phase (cfg_div+1 cycles).
  - cfg_div=0 gives MDC = clk/2.
- **Driving:** mdio_o and mdio_t update on the same clk edge that drives mdc low, i.e. at the start of each bit.
- **Sampling:** mdio_i is registered on the clk edge that drives mdc high. This captures the value the PHY launched after the previous rising MDC.
- **Handshake sequence:**
  - cmd_ready falls on the cycle after accept, and busy rises on that cycle.
  - The first bit's low phase starts on that same cycle.
- **Frame length:** N = 32 + (cfg_pre_en ? PRE_LEN : 0) bits.
- **Completion:** rsp_valid is high for exactly 1 clk, in the cycle after the last bit's high phase ends (DONE). rsp_data and rsp_err are valid in that cycle and hold until the next accept.
- **Latency:** accept edge to rsp_valid = N*2*(cfg_div+1) + 1 clk.
- **Back-to-back:** cmd_ready returns high the cycle after rsp_valid. The minimum gap between frames is 2 clk, with mdc low throughout the gap.
- **No response backpressure:** rsp_valid is a pulse and the consumer must capture it.

## Test plan
- **C22 write:** cfg_div=1, pre on; cmd_c45=0, op=01, phy=0x03, reg=0x1F, data=0xA55A -> mdc period 4 clk; 64 bits observed on mdio_o = 32×1, 0101 00011 11111 10, A55A; rsp_valid at accept+257 clk; rsp_data=0, rsp_err=0.
- **C22 read:** PHY model drives TA second bit 0 and data 0xBEEF -> mdio_t=1 from TA onward; rsp_data=0xBEEF, rsp_err=0.
- **C45 sequence, pre off:** address frame (op 00, data 0x0010), then post-read-increment (op 10) with the PHY returning 0x1234 -> each frame is 32 bits; ST=00; second response rsp_data=0x1234; the gap between frames is exactly 2 clk.
- **TA error:** read with the PHY leaving the bus high (mdio_i=1 throughout) -> rsp_err=1, rsp_data=0xFFFF.
- **Reset and config stability:** assert rst_n low during DATA of a write -> mdio_t=1, mdc=0, cmd_ready=1 immediately; no rsp_valid. After release, a new command completes normally. Changing cfg_div mid-frame does not alter the mdc period.

Source files
------------

// File: rtl/mdio_master_if.sv
// Command/response channel between the register bridge and the MDIO master.
// "master" is the command issuer; "slave" is the MDIO engine.
interface mdio_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_c45;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_phy;
   logic [4:0]  cmd_reg;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   modport master (
      output cmd_valid, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
   );
endinterface

// File: rtl/mdio_master.sv
// MDIO management master: Clause 22 / Clause 45 frames, runtime MDC divider,
// optional preamble, single-pulse read response with turnaround error flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | pad released, mdc low, waiting for a command
// PRE    | PRE_LEN preamble bits of 1
// HDR    | 14 header bits: ST, OP, PHYAD, REGAD, MSB first
// TA     | 2 turnaround bits (driven 1,0 on writes, released on reads)
// DATA   | 16 data bits, driven on writes, sampled on reads
// DONE   | one cycle, rsp_valid high
module mdio_master #(
   parameter int DIV_W   = 8,
   parameter int PRE_LEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_pre_en,
   mdio_master_if.slave     bus,
   output logic             mdc,
   output logic             mdio_o,
   output logic             mdio_t,
   input  logic             mdio_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [5:0]         bit_cnt_q, bit_cnt_d;
   logic [31:0]        tx_sr_q, tx_sr_d;
   logic [15:0]        rx_sr_q, rx_sr_d;
   logic               rd_q, rd_d;
   logic               ta_err_q, ta_err_d;

   logic               mdc_q, mdc_d;
   logic               mdio_o_q, mdio_o_d;
   logic               mdio_t_q, mdio_t_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               busy_q, busy_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [15:0]        rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;

   logic               rd_dec;
   logic [31:0]        frame_w;

   // Read-type decode differs between the two clauses.
   assign rd_dec  = bus.cmd_c45 ? bus.cmd_op[1] : (bus.cmd_op == 2'b10);
   assign frame_w = {1'b0, ~bus.cmd_c45, bus.cmd_op, bus.cmd_phy, bus.cmd_reg,
                     2'b10, rd_dec ? 16'h0000 : bus.cmd_data};

   assign mdc           = mdc_q;
   assign mdio_o        = mdio_o_q;
   assign mdio_t        = mdio_t_q;
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         div_q       <= '0;
         bit_cnt_q   <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         rd_q        <= 1'b0;
         ta_err_q    <= 1'b0;
         mdc_q       <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_t_q    <= 1'b1;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         div_q       <= div_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         rd_q        <= rd_d;
         ta_err_q    <= ta_err_d;
         mdc_q       <= mdc_d;
         mdio_o_q    <= mdio_o_d;
         mdio_t_q    <= mdio_t_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      div_d       = div_q;
      bit_cnt_d   = bit_cnt_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      rd_d        = rd_q;
      ta_err_d    = ta_err_q;
      mdc_d       = mdc_q;
      mdio_o_d    = mdio_o_q;
      mdio_t_d    = mdio_t_q;
      cmd_ready_d = cmd_ready_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            mdc_d       = 1'b0;
            mdio_o_d    = 1'b1;
            mdio_t_d    = 1'b1;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            if (bus.cmd_valid && cmd_ready_q) begin
               // Everything the frame needs is captured here; inputs may change freely afterwards.
               div_d       = cfg_div;
               div_cnt_d   = cfg_div;
               rd_d        = rd_dec;
               tx_sr_d     = frame_w;
               rx_sr_d     = '0;
               ta_err_d    = 1'b0;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               mdio_t_d    = 1'b0;
               if (cfg_pre_en) begin
                  state_d   = S_PRE;
                  bit_cnt_d = 6'(PRE_LEN - 1);
                  mdio_o_d  = 1'b1;
               end else begin
                  state_d   = S_HDR;
                  bit_cnt_d = 6'd13;
                  mdio_o_d  = frame_w[31];
               end
            end
         end

         S_PRE, S_HDR, S_TA, S_DATA: begin
            if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - 1'b1;
            end else if (!mdc_q) begin
               // Rising MDC: sample what the PHY launched during the low phase.
               mdc_d     = 1'b1;
               div_cnt_d = div_q;
               if (state_q == S_TA && bit_cnt_q == 6'd0)
                  ta_err_d = mdio_i;
               if (state_q == S_DATA)
                  rx_sr_d = {rx_sr_q[14:0], mdio_i};
            end else begin
               mdc_d     = 1'b0;
               div_cnt_d = div_q;
               if (bit_cnt_q != 6'd0) begin
                  bit_cnt_d = bit_cnt_q - 6'd1;
                  if (state_q != S_PRE) begin
                     tx_sr_d  = {tx_sr_q[30:0], 1'b0};
                     mdio_o_d = tx_sr_q[30];
                  end
               end else begin
                  case (state_q)
                     S_PRE: begin
                        state_d   = S_HDR;
                        bit_cnt_d = 6'd13;
                        mdio_o_d  = tx_sr_q[31];
                     end
                     S_HDR: begin
                        state_d   = S_TA;
                        bit_cnt_d = 6'd1;
                        tx_sr_d   = {tx_sr_q[30:0], 1'b0};
                        mdio_o_d  = tx_sr_q[30];
                        mdio_t_d  = rd_q;
                     end
                     S_TA: begin
                        state_d   = S_DATA;
                        bit_cnt_d = 6'd15;
                        tx_sr_d   = {tx_sr_q[30:0], 1'b0};
                        mdio_o_d  = tx_sr_q[30];
                     end
                     S_DATA: begin
                        state_d     = S_DONE;
                        mdio_o_d    = 1'b1;
                        mdio_t_d    = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rd_q ? rx_sr_q : 16'h0000;
                        rsp_err_d   = rd_q & ta_err_q;
                     end
                     default: ;
                  endcase
               end
            end
         end

         S_DONE: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule
